// File: rtl/add_seq_ctrl.sv
// Byte-serial wide add/subtract controller driving a shared combinational 8-bit adder slice.
// Optional ADD_SEQ_BACK2BACK_EN: accept a new request on the same edge that retires a result.
module add_seq_ctrl #(
  parameter int NBYTES = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start_valid,
  output logic                start_ready,
  input  logic [8*NBYTES-1:0] op_a,
  input  logic [8*NBYTES-1:0] op_b,
  input  logic                op_sub,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [8*NBYTES-1:0] res_sum,
  output logic                res_cout,
  output logic                res_ovf,
  output logic                busy,
  output logic [7:0]          slice_a,
  output logic [7:0]          slice_b,
  output logic                slice_cin,
  input  logic [7:0]          slice_sum,
  input  logic                slice_cout
);

  localparam int W  = 8 * NBYTES;
  localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic [W-1:0]   sum_q, sum_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic           carry_q, carry_d;
  logic           cout_q, cout_d;
  logic           ovf_q, ovf_d;
  logic           load;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    sum_d       = sum_q;
    idx_d       = idx_q;
    carry_d     = carry_q;
    cout_d      = cout_q;
    ovf_d       = ovf_q;
    load        = 1'b0;
    start_ready = 1'b0;
    res_valid   = 1'b0;
    slice_a     = '0;
    slice_b     = '0;
    slice_cin   = 1'b0;

    case (state_q)
      IDLE: begin
        start_ready = 1'b1;
        load        = start_valid;
      end
      RUN: begin
        slice_a   = a_q[idx_q*8 +: 8];
        slice_b   = b_q[idx_q*8 +: 8];
        slice_cin = carry_q;
        sum_d[idx_q*8 +: 8] = slice_sum;
        carry_d   = slice_cout;
        if (idx_q == LAST) begin
          // Final carry is reported only; it never wraps back into the sum.
          cout_d  = slice_cout;
          ovf_d   = (a_q[W-1] == b_q[W-1]) && (slice_sum[7] != a_q[W-1]);
          idx_d   = '0;
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        res_valid = 1'b1;
        if (res_ready) begin
          state_d = IDLE;
`ifdef ADD_SEQ_BACK2BACK_EN
          start_ready = 1'b1;
          load        = start_valid;
`endif
        end
      end
      default: state_d = IDLE;
    endcase

    // Subtract is A + ~B + 1: invert B once at capture and seed the carry.
    if (load) begin
      a_d     = op_a;
      b_d     = op_sub ? ~op_b : op_b;
      carry_d = op_sub;
      idx_d   = '0;
      state_d = RUN;
    end
  end

  assign res_sum  = sum_q;
  assign res_cout = cout_q;
  assign res_ovf  = ovf_q;
  assign busy     = (state_q != IDLE);

endmodule
